// File: rtl/pixel_stream_out.sv
// ============================================================================
//  Module   : pixel_stream_out
//  Purpose  : FWFT pixel FIFO feeding an AXI4-Stream video output, with
//             SOF/EOL framing, early upstream stall and sticky drop flag.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pixel_stream_out #(
    parameter int X_RES      = 640,
    parameter int Y_RES      = 480,
    parameter int FIFO_DEPTH = 16,
    parameter int PIPE_SLACK = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [23:0] shade_in,
    output logic        stall_out,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        frame_done,
    output logic        overflow,
    input  logic        clear_overflow
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam int c_xw = (X_RES > 1) ? $clog2(X_RES) : 1;
    localparam int c_yw = (Y_RES > 1) ? $clog2(Y_RES) : 1;

    localparam logic [c_cw-1:0] c_depth     = c_cw'(FIFO_DEPTH);
    localparam logic [c_cw-1:0] c_stall_th  = c_cw'(FIFO_DEPTH - PIPE_SLACK);
    localparam logic [c_cw-1:0] c_cnt_zero  = '0;
    localparam logic [c_aw-1:0] c_ptr_one   = c_aw'(1);
    localparam logic [c_xw-1:0] c_x_last    = c_xw'(X_RES - 1);
    localparam logic [c_yw-1:0] c_y_last    = c_yw'(Y_RES - 1);
    localparam logic [c_xw-1:0] c_x_one     = c_xw'(1);
    localparam logic [c_yw-1:0] c_y_one     = c_yw'(1);

    logic [23:0]     mem_q [FIFO_DEPTH];
    logic [c_aw-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cw-1:0] count_q, count_d;
    logic [c_xw-1:0] x_q, x_d;
    logic [c_yw-1:0] y_q, y_d;
    logic            stall_q, stall_d;
    logic            overflow_q, overflow_d;
    logic            frame_done_q, frame_done_d;

    logic w_empty;
    logic w_full;
    logic w_rd_en;
    logic w_wr_en;
    logic w_drop;
    logic w_x_last;
    logic w_y_last;

    assign w_empty  = (count_q == c_cnt_zero);
    assign w_full   = (count_q == c_depth);
    assign w_rd_en  = !w_empty && m_axis_tready;
    // A full FIFO still takes a pixel when the head leaves in the same cycle.
    assign w_wr_en  = valid_in && (!w_full || w_rd_en);
    assign w_drop   = valid_in && w_full && !w_rd_en;
    assign w_x_last = (x_q == c_x_last);
    assign w_y_last = (y_q == c_y_last);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        x_d          = x_q;
        y_d          = y_q;
        overflow_d   = overflow_q;
        frame_done_d = 1'b0;

        if (w_wr_en) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end
        if (w_rd_en) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
        count_d = count_q + {{(c_cw-1){1'b0}}, w_wr_en} - {{(c_cw-1){1'b0}}, w_rd_en};

        if (w_rd_en) begin
            if (w_x_last) begin
                x_d = '0;
                y_d = w_y_last ? '0 : (y_q + c_y_one);
                frame_done_d = w_y_last;
            end else begin
                x_d = x_q + c_x_one;
            end
        end

        // Drop beats clear so a loss in the clearing cycle is never hidden.
        if (w_drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end

        stall_d = (count_d >= c_stall_th);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            stall_q      <= 1'b0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            x_q          <= x_d;
            y_q          <= y_d;
            stall_q      <= stall_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= shade_in;
        end
    end

    assign m_axis_tvalid = !w_empty;
    assign m_axis_tdata  = m_axis_tvalid ? {8'h00, mem_q[rd_ptr_q]} : 32'h0;
    assign m_axis_tuser  = m_axis_tvalid && (x_q == '0) && (y_q == '0);
    assign m_axis_tlast  = m_axis_tvalid && w_x_last;
    assign stall_out     = stall_q;
    assign overflow      = overflow_q;
    assign frame_done    = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_pixel_stream_out.sv
// ============================================================================
//  Module   : tb_pixel_stream_out
//  Purpose  : Self-checking bench for pixel_stream_out using a queue model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pixel_stream_out;

    localparam int X_RES      = 4;
    localparam int Y_RES      = 2;
    localparam int FIFO_DEPTH = 16;
    localparam int PIPE_SLACK = 6;
    localparam int FRAME      = X_RES * Y_RES;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in = 1'b0;
    logic [23:0] shade_in = '0;
    logic        stall_out;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        frame_done;
    logic        overflow;
    logic        clear_overflow = 1'b0;

    pixel_stream_out #(
        .X_RES(X_RES), .Y_RES(Y_RES), .FIFO_DEPTH(FIFO_DEPTH), .PIPE_SLACK(PIPE_SLACK)
    ) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .shade_in(shade_in),
        .stall_out(stall_out), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .frame_done(frame_done), .overflow(overflow), .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    // Reference model: pixel queue, handshake position in frame, sticky flag.
    logic [23:0] mq[$];
    int          m_pos;
    bit          m_ov;
    bit          m_fd;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit          v;
        logic [23:0] d;
        bit          exp_valid;
        logic [31:0] exp_data;
        bit          exp_user;
        bit          exp_last;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pos = 0;
        m_ov  = 1'b0;
        m_fd  = 1'b0;
    endtask

    task automatic check_model();
        bit          ev;
        logic [31:0] ed;
        ev = (mq.size() > 0);
        ed = ev ? {8'h00, mq[0]} : 32'h0;
        chk("tvalid", {31'b0, m_axis_tvalid}, {31'b0, ev});
        chk("tdata", m_axis_tdata, ed);
        chk("tuser", {31'b0, m_axis_tuser}, {31'b0, ev && (m_pos == 0)});
        chk("tlast", {31'b0, m_axis_tlast}, {31'b0, ev && ((m_pos % X_RES) == X_RES - 1)});
        chk("stall", {31'b0, stall_out}, {31'b0, mq.size() >= FIFO_DEPTH - PIPE_SLACK});
        chk("overflow", {31'b0, overflow}, {31'b0, m_ov});
        chk("frame_done", {31'b0, frame_done}, {31'b0, m_fd});
    endtask

    // Called at a falling edge; drives inputs, steps model across the rising edge, checks.
    task automatic cycle(input bit v, input logic [23:0] d, input bit rdy, input bit clr);
        bit rd, full, wr, drop;
        valid_in       = v;
        shade_in       = d;
        m_axis_tready  = rdy;
        clear_overflow = clr;
        rd   = (mq.size() > 0) && rdy;
        full = (mq.size() == FIFO_DEPTH);
        wr   = v && (!full || rd);
        drop = v && full && !rd;
        @(posedge clk);
        m_fd = 1'b0;
        if (rd) begin
            void'(mq.pop_front());
            if (m_pos == FRAME - 1) m_fd = 1'b1;
            m_pos = (m_pos + 1) % FRAME;
        end
        if (wr) mq.push_back(d);
        if (drop) m_ov = 1'b1;
        else if (clr) m_ov = 1'b0;
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        valid_in = 1'b0; m_axis_tready = 1'b0; clear_overflow = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_tvalid", {31'b0, m_axis_tvalid}, 32'h0);
        chk("rst_tdata", m_axis_tdata, 32'h0);
        chk("rst_flags", {28'b0, stall_out, overflow, frame_done, m_axis_tuser}, 32'h0);
    endtask

    initial begin
        vec_t tbl[5];
        int   first_stall;
        int   fd_pulses;
        int   drained;
        int   sent;
        int   guard;
        bit   v;

        tbl[0] = '{1'b1, 24'hFF0000, 1'b1, 32'h00FF0000, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 24'h00FF00, 1'b1, 32'h0000FF00, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 24'h0000FF, 1'b1, 32'h000000FF, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 24'h808080, 1'b1, 32'h00808080, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 24'h000000, 1'b0, 32'h00000000, 1'b0, 1'b0};

        model_reset();
        @(negedge clk);
        do_reset();

        // Basic ordering and one-cycle latency
        for (int i = 0; i < 5; i++) begin
            cycle(tbl[i].v, tbl[i].d, 1'b1, 1'b0);
            chk("tbl_tvalid", {31'b0, m_axis_tvalid}, {31'b0, tbl[i].exp_valid});
            chk("tbl_tdata", m_axis_tdata, tbl[i].exp_data);
            chk("tbl_tuser", {31'b0, m_axis_tuser}, {31'b0, tbl[i].exp_user});
            chk("tbl_tlast", {31'b0, m_axis_tlast}, {31'b0, tbl[i].exp_last});
            chk("tbl_overflow", {31'b0, overflow}, 32'h0);
        end

        // Full frame plus first pixel of the next one
        do_reset();
        fd_pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(i < 9, 24'h100000 + 24'(i), 1'b1, 1'b0);
            if (frame_done) begin
                fd_pulses++;
                chk("frame_done_cycle", i, 8);
            end
        end
        chk("frame_done_pulses", fd_pulses, 1);

        // Fill with tready low: stall threshold, drop, set-wins-over-clear
        do_reset();
        first_stall = -1;
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 24'h200000 + 24'(i), 1'b0, 1'b0);
            if (stall_out && first_stall < 0) first_stall = i;
        end
        chk("stall_rise_idx", first_stall, 9);
        chk("ovf_after_drop", {31'b0, overflow}, 32'h1);
        cycle(1'b1, 24'h2000AA, 1'b0, 1'b1);
        chk("ovf_set_wins", {31'b0, overflow}, 32'h1);
        cycle(1'b0, 24'h0, 1'b0, 1'b1);
        chk("ovf_cleared", {31'b0, overflow}, 32'h0);
        // Full FIFO with simultaneous read and write
        cycle(1'b1, 24'h2000BB, 1'b1, 1'b0);
        chk("full_rw_ovf", {31'b0, overflow}, 32'h0);
        chk("full_rw_stall", {31'b0, stall_out}, 32'h1);
        drained = 0;
        guard = 0;
        while (m_axis_tvalid && guard < 40) begin
            drained++;
            guard++;
            cycle(1'b0, 24'h0, 1'b1, 1'b0);
        end
        chk("drain_count", drained, 16);

        // Randomized traffic against the model
        do_reset();
        sent = 0;
        guard = 0;
        while ((sent < 1000 || mq.size() > 0) && guard < 20000) begin
            v = (sent < 1000) && !(mq.size() >= FIFO_DEPTH - PIPE_SLACK) && ($urandom_range(3) != 0);
            cycle(v, 24'($urandom), 1'($urandom), 1'b0);
            if (v) sent++;
            guard++;
        end
        chk("rand_done", {31'b0, guard < 20000}, 32'h1);
        chk("rand_no_ovf", {31'b0, overflow}, 32'h0);

        // Asynchronous reset with data buffered mid-frame
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 24'h300000 + 24'(i), 1'b1, 1'b0);
        cycle(1'b0, 24'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 24'h310000 + 24'(i), 1'b0, 1'b0);
        chk("pre_rst_tvalid", {31'b0, m_axis_tvalid}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_tvalid", {31'b0, m_axis_tvalid}, 32'h0);
        chk("async_rst_tuser", {31'b0, m_axis_tuser}, 32'h0);
        @(negedge clk);
        model_reset();
        rst = 1'b1;
        cycle(1'b1, 24'hABCDEF, 1'b1, 1'b0);
        chk("post_rst_tuser", {31'b0, m_axis_tuser}, 32'h1);
        chk("post_rst_tdata", m_axis_tdata, 32'h00ABCDEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
